// File: rtl/riscv_hwloop_ctrl_if.sv
// Hardware-loop controller bus: fetch-side jump handshake plus the
// loop register file values and the decrement strobes going back to it.
interface riscv_hwloop_ctrl_if #(
    parameter int N_LOOPS = 2
);
    // Fetch stage view of the instruction stream
    logic [31:0]            current_pc_i;
    logic                   pc_valid_i;
    logic                   flush_i;

    // Loop register file contents and write strobes {cnt,end,start}
    logic [N_LOOPS*32-1:0]  hwlp_start_addr_i;
    logic [N_LOOPS*32-1:0]  hwlp_end_addr_i;
    logic [N_LOOPS*32-1:0]  hwlp_counter_i;
    logic [2:0]             hwlp_we_i;

    // Jump request handshake towards fetch
    logic                   jump_o;
    logic [31:0]            jump_target_o;
    logic                   jump_ack_i;

    // One-hot decrement strobe back to the loop counters
    logic [N_LOOPS-1:0]     hwlp_dec_cnt_o;

    // Environment side: fetch stage and loop register file
    modport master (
        output current_pc_i, pc_valid_i, flush_i,
        output hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i, hwlp_we_i,
        output jump_ack_i,
        input  jump_o, jump_target_o, hwlp_dec_cnt_o
    );

    // Controller side
    modport slave (
        input  current_pc_i, pc_valid_i, flush_i,
        input  hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i, hwlp_we_i,
        input  jump_ack_i,
        output jump_o, jump_target_o, hwlp_dec_cnt_o
    );
endinterface

// File: rtl/riscv_hwloop_ctrl.sv
// Hardware-loop controller. Watches the fetched PC against every loop's end
// address; when the innermost matching loop still has iterations left it
// raises a registered jump request back to the loop start and holds it until
// fetch acknowledges (or a flush cancels it). The loop counter is decremented
// when the jump is accepted, or immediately when the last iteration ends.
module riscv_hwloop_ctrl #(
    parameter int N_LOOPS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_hwloop_ctrl_if.slave   bus
);

    localparam int SEL_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_jump;
    logic [31:0]        r_target;
    logic [SEL_W-1:0]   r_sel;

    logic [N_LOOPS-1:0] w_match;
    logic               w_any;
    logic [SEL_W-1:0]   w_sel;
    logic [31:0]        w_sel_cnt;
    logic [31:0]        w_sel_start;
    logic               w_detect;
    logic               w_take_jump;
    logic               w_exit;
    logic               w_ack_accept;
    logic [N_LOOPS-1:0] w_dec;

    // Per-loop end-of-body match: exact 32-bit PC compare, loop still live
    always_comb begin
        w_match = '0;
        for (int k = 0; k < N_LOOPS; k++) begin
            w_match[k] = (bus.current_pc_i == bus.hwlp_end_addr_i[32*k +: 32]) &&
                         (bus.hwlp_counter_i[32*k +: 32] != 32'd0);
        end
    end

    // Priority select: the lowest-numbered (innermost) matching loop wins
    always_comb begin
        w_any       = 1'b0;
        w_sel       = '0;
        w_sel_cnt   = '0;
        w_sel_start = '0;
        for (int k = N_LOOPS - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_any       = 1'b1;
                w_sel       = SEL_W'(k);
                w_sel_cnt   = bus.hwlp_counter_i[32*k +: 32];
                w_sel_start = bus.hwlp_start_addr_i[32*k +: 32];
            end
        end
    end

    // Detection only while idle, on a valid PC, with no register write or
    // redirect in flight; reset also silences the combinational decrement
    always_comb begin
        w_detect     = rst_n && (r_state == IDLE) && bus.pc_valid_i &&
                       (bus.hwlp_we_i == 3'b000) && !bus.flush_i && w_any;
        w_take_jump  = w_detect && (w_sel_cnt >= 32'd2);
        w_exit       = w_detect && (w_sel_cnt == 32'd1);
        w_ack_accept = rst_n && (r_state == PEND) && bus.jump_ack_i && !bus.flush_i;
    end

    // One-hot decrement: loop exit in IDLE or accepted jump in PEND
    always_comb begin
        w_dec = '0;
        for (int k = 0; k < N_LOOPS; k++) begin
            if (w_exit && (w_sel == SEL_W'(k))) begin
                w_dec[k] = 1'b1;
            end else if (w_ack_accept && (r_sel == SEL_W'(k))) begin
                w_dec[k] = 1'b1;
            end
        end
    end

    // Jump request FSM with registered request, target and loop index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_jump   <= 1'b0;
            r_target <= '0;
            r_sel    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take_jump) begin
                        r_state  <= PEND;
                        r_jump   <= 1'b1;
                        r_target <= w_sel_start;
                        r_sel    <= w_sel;
                    end
                end
                PEND: begin
                    if (bus.flush_i || bus.jump_ack_i) begin
                        r_state <= IDLE;
                        r_jump  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_jump  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.jump_o         = r_jump;
    assign bus.jump_target_o  = r_target;
    assign bus.hwlp_dec_cnt_o = w_dec;

endmodule

// File: tb/tb_riscv_hwloop_ctrl.sv
// Self-checking bench for the hardware-loop controller: directed scenarios
// with hand-derived expectations followed by a randomized run compared
// against a cycle-level behavioural model of the loop rules.
module tb_riscv_hwloop_ctrl;

    localparam int N_LOOPS = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    riscv_hwloop_ctrl_if #(.N_LOOPS(N_LOOPS)) hw();

    riscv_hwloop_ctrl #(.N_LOOPS(N_LOOPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hw.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Loop register file model driven onto the bus
    logic [31:0] mStart [N_LOOPS];
    logic [31:0] mEnd   [N_LOOPS];
    logic [31:0] mCnt   [N_LOOPS];

    // Reference state: is a jump outstanding, where to, for which loop
    bit               mPend;
    bit               nPend;
    logic [31:0]      mTarget;
    logic [31:0]      nTarget;
    int               mSel;
    int               nSel;
    logic [N_LOOPS-1:0] expDec;

    // Reference rules evaluated on the inputs currently on the bus
    task automatic evalModel();
        int hit;
        expDec  = '0;
        nPend   = mPend;
        nTarget = mTarget;
        nSel    = mSel;
        if (!rst_n) begin
            nPend   = 1'b0;
            nTarget = '0;
            nSel    = 0;
        end else if (!mPend) begin
            if (hw.pc_valid_i && hw.hwlp_we_i == 3'b000 && !hw.flush_i) begin
                hit = -1;
                for (int k = 0; k < N_LOOPS; k++) begin
                    if (hit < 0 && hw.current_pc_i == mEnd[k] && mCnt[k] != 0) hit = k;
                end
                if (hit >= 0) begin
                    if (mCnt[hit] > 32'd1) begin
                        nPend   = 1'b1;
                        nTarget = mStart[hit];
                        nSel    = hit;
                    end else begin
                        expDec[hit] = 1'b1;
                    end
                end
            end
        end else begin
            if (hw.flush_i) begin
                nPend = 1'b0;
            end else if (hw.jump_ack_i) begin
                expDec[mSel] = 1'b1;
                nPend = 1'b0;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge and evaluate the model
    task automatic applyStimulus(input logic [31:0] pc, input logic valid,
                                 input logic [2:0] we, input logic flush, input logic ack);
        @(negedge clk);
        hw.current_pc_i = pc;
        hw.pc_valid_i   = valid;
        hw.hwlp_we_i    = we;
        hw.flush_i      = flush;
        hw.jump_ack_i   = ack;
        for (int k = 0; k < N_LOOPS; k++) begin
            hw.hwlp_start_addr_i[32*k +: 32] = mStart[k];
            hw.hwlp_end_addr_i[32*k +: 32]   = mEnd[k];
            hw.hwlp_counter_i[32*k +: 32]    = mCnt[k];
        end
        #1;
        evalModel();
    endtask

    // Advance the model across the rising edge; counters follow decrements
    task automatic commit();
        @(posedge clk);
        mPend   = nPend;
        mTarget = nTarget;
        mSel    = nSel;
        for (int k = 0; k < N_LOOPS; k++) begin
            if (expDec[k]) mCnt[k] = mCnt[k] - 32'd1;
        end
    endtask

    task automatic setLoop(input int k, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        mStart[k] = s;
        mEnd[k]   = e;
        mCnt[k]   = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setLoop(0, 32'h0F0, 32'h100, 32'd1);
        setLoop(1, 32'h500, 32'h100, 32'd3);
        mPend = 1'b0; mTarget = '0; mSel = 0;
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_jump got=%b exp=0", hw.jump_o); end
        nCompared++; if (hw.jump_target_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_target got=%h exp=0", hw.jump_target_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_dec got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic_jump();
        setLoop(0, 32'h0F0, 32'h100, 32'd3);
        setLoop(1, 32'h5000, 32'h9000, 32'd0);
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_jump_early got=%b exp=0", hw.jump_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_dec_detect got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_jump_req got=%b exp=1", hw.jump_o); end
        nCompared++; if (hw.jump_target_o !== 32'h0F0) begin nMismatched++; $display("[TB] FAIL basic_target got=%h exp=000000f0", hw.jump_target_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_dec_wait got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_jump_hold got=%b exp=1", hw.jump_o); end
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b0, 1'b1);
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL basic_dec_ack got=%b exp=01", hw.hwlp_dec_cnt_o); end
        nCompared++; if (hw.jump_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_jump_ackcycle got=%b exp=1", hw.jump_o); end
        commit();
        applyStimulus(32'h108, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_jump_drop got=%b exp=0", hw.jump_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_dec_after got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
    endtask

    task automatic test_exit();
        mCnt[0] = 32'd1;
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL exit_dec got=%b exp=01", hw.hwlp_dec_cnt_o); end
        commit();
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL exit_jump got=%b exp=0", hw.jump_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL exit_cnt0_dec got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
    endtask

    task automatic test_priority();
        setLoop(0, 32'h1000, 32'h200, 32'd5);
        setLoop(1, 32'h2000, 32'h200, 32'd4);
        applyStimulus(32'h200, 1'b1, 3'b000, 1'b0, 1'b0);
        commit();
        applyStimulus(32'h204, 1'b0, 3'b000, 1'b0, 1'b1);
        nCompared++; if (hw.jump_target_o !== 32'h1000) begin nMismatched++; $display("[TB] FAIL prio_target0 got=%h exp=00001000", hw.jump_target_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL prio_dec0 got=%b exp=01", hw.hwlp_dec_cnt_o); end
        commit();
        mCnt[0] = 32'd0;
        applyStimulus(32'h200, 1'b1, 3'b000, 1'b0, 1'b0);
        commit();
        applyStimulus(32'h204, 1'b0, 3'b000, 1'b0, 1'b1);
        nCompared++; if (hw.jump_target_o !== 32'h2000) begin nMismatched++; $display("[TB] FAIL prio_target1 got=%h exp=00002000", hw.jump_target_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b10) begin nMismatched++; $display("[TB] FAIL prio_dec1 got=%b exp=10", hw.hwlp_dec_cnt_o); end
        commit();
    endtask

    task automatic test_flush();
        setLoop(0, 32'h0F0, 32'h100, 32'd3);
        setLoop(1, 32'h5000, 32'h9000, 32'd0);
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b1, 1'b1);
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL flush_dec got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_jump_drop got=%b exp=0", hw.jump_o); end
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b0, 1'b1);
        nCompared++; if (hw.jump_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_rematch got=%b exp=1", hw.jump_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL flush_rematch_dec got=%b exp=01", hw.hwlp_dec_cnt_o); end
        commit();
    endtask

    task automatic test_suppress_and_reset();
        mCnt[0] = 32'd3;
        applyStimulus(32'h100, 1'b1, 3'b100, 1'b0, 1'b0);
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL we_dec got=%b exp=00", hw.hwlp_dec_cnt_o); end
        commit();
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b1, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL we_jump got=%b exp=0", hw.jump_o); end
        commit();
        applyStimulus(32'h100, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL idleflush_jump got=%b exp=0", hw.jump_o); end
        commit();
        applyStimulus(32'h104, 1'b0, 3'b000, 1'b0, 1'b1);
        nCompared++; if (hw.jump_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_pre_jump got=%b exp=1", hw.jump_o); end
        rst_n = 1'b0;
        #1;
        evalModel();
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_jump got=%b exp=0", hw.jump_o); end
        nCompared++; if (hw.hwlp_dec_cnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL rst_mid_dec got=%b exp=00", hw.hwlp_dec_cnt_o); end
        nCompared++; if (hw.jump_target_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_target got=%h exp=0", hw.jump_target_o); end
        commit();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int jumps;
        int decs;
        jumps = 0;
        decs  = 0;
        setLoop(0, 32'h300, 32'h300, 32'd3);
        setLoop(1, 32'h5000, 32'h9000, 32'd0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(32'h300, 1'b1, 3'b000, 1'b0, 1'b1);
            if (hw.jump_o === 1'b1) jumps++;
            decs += $countones(hw.hwlp_dec_cnt_o);
            commit();
        end
        nCompared++; if (jumps !== 2) begin nMismatched++; $display("[TB] FAIL b2b_jumps got=%0d exp=2", jumps); end
        nCompared++; if (decs !== 3) begin nMismatched++; $display("[TB] FAIL b2b_decs got=%0d exp=3", decs); end
        applyStimulus(32'h300, 1'b1, 3'b000, 1'b0, 1'b0);
        nCompared++; if (hw.jump_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_end_jump got=%b exp=0", hw.jump_o); end
        commit();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [2:0]  we;
        logic [31:0] cntPick;
        int          r;
        int          k;
        setLoop(0, 32'h100, 32'h400, 32'd3);
        setLoop(1, 32'h200, 32'h404, 32'd2);
        for (int c = 0; c < 400; c++) begin
            we = 3'b000;
            if ($urandom_range(0, 7) == 0) begin
                we = 3'($urandom_range(1, 7));
                k  = $urandom_range(0, N_LOOPS - 1);
                r  = $urandom_range(0, 5);
                case (r)
                    0: cntPick = 32'd0;
                    1: cntPick = 32'd1;
                    2: cntPick = 32'd2;
                    3: cntPick = 32'd3;
                    4: cntPick = 32'hFFFF_FFFF;
                    default: cntPick = $urandom;
                endcase
                setLoop(k, $urandom, 32'h400 + 32'(4 * $urandom_range(0, 2)), cntPick);
            end
            r = $urandom_range(0, 9);
            if (r < 4) pc = mEnd[0];
            else if (r < 7) pc = mEnd[1];
            else pc = $urandom;
            applyStimulus(pc, ($urandom_range(0, 4) != 0), we,
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            nCompared++; if (hw.jump_o !== mPend) begin nMismatched++; $display("[TB] FAIL rand_jump c=%0d got=%b exp=%b", c, hw.jump_o, mPend); end
            if (mPend) begin
                nCompared++; if (hw.jump_target_o !== mTarget) begin nMismatched++; $display("[TB] FAIL rand_target c=%0d got=%h exp=%h", c, hw.jump_target_o, mTarget); end
            end
            nCompared++; if (hw.hwlp_dec_cnt_o !== expDec) begin nMismatched++; $display("[TB] FAIL rand_dec c=%0d got=%b exp=%b", c, hw.hwlp_dec_cnt_o, expDec); end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_basic_jump();
        test_exit();
        test_priority();
        test_flush();
        test_suppress_and_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
